// File: rtl/fb_select.sv
// fb_select: walks the clauses of one class and emits a per-clause feedback decision (fb_en true with probability d/T) plus its type.
// Optional build macro FB_SKIP_EN: clauses that get no feedback are dropped from the stream rather than emitted.
module fb_select #(
    parameter int unsigned T_WIDTH   = 8,
    parameter int unsigned N_CLAUSES = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [T_WIDTH-1:0]           d,
    input  logic [T_WIDTH:0]             T,
    input  logic                         q,
    output logic                         busy,
    output logic                         fb_valid,
    input  logic                         fb_ready,
    output logic [$clog2(N_CLAUSES)-1:0] fb_idx,
    output logic                         fb_en,
    output logic                         fb_type,
    output logic                         done
);
    localparam int unsigned        IDX_W     = $clog2(N_CLAUSES);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_CLAUSES - 1);
    localparam logic [15:0]        LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_EMIT, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [T_WIDTH-1:0] d_q, d_d;
    logic [T_WIDTH-1:0] t_q, t_d;
    logic               q_q, q_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fb_valid_q, fb_valid_d;
    logic [IDX_W-1:0]   fb_idx_q, fb_idx_d;
    logic               fb_en_q, fb_en_d;
    logic               fb_type_q, fb_type_d;

    logic [T_WIDTH-1:0] rnd;
    logic [15:0]        lfsr_step;
    logic               draw_decided;
    logic               draw_en;
    logic               draw_step;
    logic               skip_clause;
    logic               unused_t_msb;

    // Only the magnitude bits of T matter; the top bit is the sign/overflow bit of the clip stage.
    assign unused_t_msb = T[T_WIDTH];
    assign rnd          = lfsr_q[T_WIDTH-1:0];
    assign lfsr_step    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

`ifdef FB_SKIP_EN
    assign skip_clause = ~draw_en;
`else
    assign skip_clause = 1'b0;
`endif

    // Rejection sampling: the degenerate ratios resolve without consuming randomness.
    always_comb begin
        draw_decided = 1'b1;
        draw_en      = 1'b0;
        draw_step    = 1'b0;
        if (t_q == '0) begin
            draw_en = 1'b0;
        end else if (d_q >= t_q) begin
            draw_en = 1'b1;
        end else if (d_q == '0) begin
            draw_en = 1'b0;
        end else begin
            draw_step = 1'b1;
            if (rnd >= t_q) begin
                draw_decided = 1'b0;
            end else begin
                draw_en = (rnd < d_q);
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        d_d        = d_q;
        t_d        = t_q;
        q_d        = q_q;
        cnt_d      = cnt_q;
        lfsr_d     = lfsr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fb_valid_d = fb_valid_q;
        fb_idx_d   = fb_idx_q;
        fb_en_d    = fb_en_q;
        fb_type_d  = fb_type_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    d_d     = d;
                    t_d     = T[T_WIDTH-1:0];
                    q_d     = q;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                if (draw_step) begin
                    lfsr_d = lfsr_step;
                end
                if (draw_decided) begin
                    if (skip_clause) begin
                        if (cnt_q == LAST_IDX) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            cnt_d = cnt_q + IDX_W'(1);
                        end
                    end else begin
                        fb_valid_d = 1'b1;
                        fb_idx_d   = cnt_q;
                        fb_en_d    = draw_en;
                        // Even clauses are positive polarity: Type I for the target class.
                        fb_type_d  = ~(q_q ^ cnt_q[0]);
                        state_d    = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (fb_ready) begin
                    fb_valid_d = 1'b0;
                    fb_en_d    = 1'b0;
                    fb_type_d  = 1'b0;
                    if (cnt_q == LAST_IDX) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + IDX_W'(1);
                        state_d = S_DRAW;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            d_q        <= '0;
            t_q        <= '0;
            q_q        <= 1'b0;
            cnt_q      <= '0;
            lfsr_q     <= LFSR_SEED;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fb_valid_q <= 1'b0;
            fb_idx_q   <= '0;
            fb_en_q    <= 1'b0;
            fb_type_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_q        <= d_d;
            t_q        <= t_d;
            q_q        <= q_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fb_valid_q <= fb_valid_d;
            fb_idx_q   <= fb_idx_d;
            fb_en_q    <= fb_en_d;
            fb_type_q  <= fb_type_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign fb_valid = fb_valid_q;
    assign fb_idx   = fb_idx_q;
    assign fb_en    = fb_en_q;
    assign fb_type  = fb_type_q;

endmodule

// File: tb/tb_fb_select.sv
// tb_fb_select: randomized bench for fb_select against a clause-level reference model of the LFSR draw process.
// Honours FB_SKIP_EN the same way as the design.
module tb_fb_select;
    localparam int          TW   = 8;
    localparam int          NC   = 16;
    localparam int          IW   = $clog2(NC);
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef FB_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          en;
        logic          typ;
    } emit_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [TW-1:0] d;
    logic [TW:0]   T;
    logic          q;
    logic          busy;
    logic          fb_valid;
    logic          fb_ready;
    logic [IW-1:0] fb_idx;
    logic          fb_en;
    logic          fb_type;
    logic          done;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    done_cnt = 0;
    emit_t obs_q[$];
    emit_t exp_q[$];
    logic [15:0] m_lfsr;
    int    m_cycles;

    fb_select #(.T_WIDTH(TW), .N_CLAUSES(NC), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .d(d), .T(T), .q(q),
        .busy(busy), .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_idx(fb_idx),
        .fb_en(fb_en), .fb_type(fb_type), .done(done)
    );

    always #5 clk = ~clk;

    // Stream monitor: a handshake seen mid-cycle completes at the next rising edge.
    always @(negedge clk) begin
        if (fb_valid === 1'b1 && fb_ready === 1'b1)
            obs_q.push_back('{idx: fb_idx, en: fb_en, typ: fb_type});
        if (done === 1'b1)
            done_cnt++;
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // One sample: each clause draws uniform numbers below t until accepted, feedback iff draw < d.
    task automatic model_sample(input int dv, input int tv, input bit qv);
        for (int i = 0; i < NC; i++) begin
            bit en;
            int r;
            int draws;
            draws = 1;
            if (tv == 0)       en = 1'b0;
            else if (dv >= tv) en = 1'b1;
            else if (dv == 0)  en = 1'b0;
            else begin
                draws = 0;
                r = tv;
                while (r >= tv) begin
                    r = int'(m_lfsr) % (1 << TW);
                    m_lfsr = lfsr_next(m_lfsr);
                    draws++;
                end
                en = (r < dv);
            end
            m_cycles += draws;
            if (en || !SKIP) begin
                exp_q.push_back('{idx: IW'(i), en: en, typ: (i % 2 == 0) ? !qv : qv});
                m_cycles += 1;
            end
        end
    endtask

    function automatic int seq_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic emit_t obs_at(input int k);
        return (k >= 0 && k < obs_q.size()) ? obs_q[k] : '1;
    endfunction

    function automatic emit_t exp_at(input int k);
        return (k >= 0 && k < exp_q.size()) ? exp_q[k] : '1;
    endfunction

    task automatic prep_model(input int dv, input int tv, input bit qv);
        exp_q.delete();
        m_cycles = 0;
        model_sample(dv, tv, qv);
    endtask

    task automatic wait_done(input int budget, output int cycles, output bit timed_out);
        bit seen;
        seen = 1'b0;
        cycles = 0;
        timed_out = 1'b0;
        while (!seen && !timed_out) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            else begin
                cycles++;
                if (cycles > budget) timed_out = 1'b1;
            end
        end
        @(posedge clk); #1;
        if (timed_out) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            m_lfsr = SEED;
        end
    endtask

    // Drives one start (inputs scrambled afterwards) and waits for done; fb_ready stays high.
    task automatic run_sample(input logic [TW-1:0] dv, input logic [TW:0] tv, input bit qv,
                              input int budget, output int cycles, output bit timed_out);
        obs_q.delete();
        @(posedge clk); #1;
        d = dv; T = tv; q = qv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        d = TW'($urandom); T = (TW+1)'($urandom); q = 1'($urandom);
        wait_done(budget, cycles, timed_out);
    endtask

    task automatic check_sample(input string name, input int cycles, input bit timed_out, input int d0);
        int k;
        n_tests++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL %s timeout: no done after %0d cycles", name, cycles);
        end
        k = seq_diff();
        n_tests++;
        if (k != -1) begin
            n_fail++;
            $display("FAIL %s seq: first diff at %0d, got %0d entries (%h), expected %0d entries (%h)",
                     name, k, obs_q.size(), obs_at(k), exp_q.size(), exp_at(k));
        end
        n_tests++;
        if (cycles !== m_cycles) begin
            n_fail++;
            $display("FAIL %s cycles: got %0d, expected %0d", name, cycles, m_cycles);
        end
        n_tests++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL %s done pulses: got %0d, expected 1", name, done_cnt - d0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; fb_ready = 1'b1; d = '0; T = '0; q = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({busy, fb_valid, fb_en, fb_type, done, fb_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got busy=%b valid=%b en=%b type=%b done=%b idx=%0d, expected all 0",
                     busy, fb_valid, fb_en, fb_type, done, fb_idx);
        end
        n_tests++;
        if (dut.lfsr_q !== SEED) begin
            n_fail++;
            $display("FAIL reset lfsr: got %h, expected %h", dut.lfsr_q, SEED);
        end
        m_lfsr = SEED;
    endtask

    task automatic test_zero_d();
        int cyc, d0;
        bit to;
        prep_model(0, 36, 1'b1);
        d0 = done_cnt;
        run_sample(8'd0, 9'd36, 1'b1, 500, cyc, to);
        check_sample("zero_d", cyc, to, d0);
    endtask

    task automatic test_full_d();
        int cyc, d0;
        bit to;
        // T bit 8 set: only the low magnitude bits (36) may be used.
        prep_model(36, 36, 1'b0);
        d0 = done_cnt;
        run_sample(8'd36, 9'h124, 1'b0, 500, cyc, to);
        check_sample("full_d", cyc, to, d0);
        n_tests++;
        if (dut.lfsr_q !== SEED) begin
            n_fail++;
            $display("FAIL full_d lfsr moved: got %h, expected %h", dut.lfsr_q, SEED);
        end
    endtask

    task automatic test_random();
        int cyc, d0, ones;
        bit to;
        ones = 0;
        for (int s = 0; s < 64; s++) begin
            prep_model(18, 36, 1'b1);
            d0 = done_cnt;
            run_sample(8'd18, 9'd36, 1'b1, 4000, cyc, to);
            check_sample($sformatf("half_d[%0d]", s), cyc, to, d0);
            foreach (obs_q[i]) ones += int'(obs_q[i].en);
        end
        n_tests++;
        if (ones < 410 || ones > 614) begin
            n_fail++;
            $display("FAIL half_d en count: got %0d, expected 410..614", ones);
        end
        for (int s = 0; s < 10; s++) begin
            int tv, dv;
            bit qv, msb;
            tv  = (s == 0) ? 0 : $urandom_range(20, 60);
            dv  = $urandom_range(0, tv + 5);
            qv  = 1'($urandom);
            msb = 1'($urandom);
            prep_model(dv, tv, qv);
            d0 = done_cnt;
            run_sample(TW'(dv), {msb, TW'(tv)}, qv, 8000, cyc, to);
            check_sample($sformatf("rand[d=%0d t=%0d q=%0d]", dv, tv, qv), cyc, to, d0);
        end
    endtask

    task automatic test_stall();
        int cyc, d0, k;
        bit to;
        emit_t held;
        prep_model(36, 36, 1'b1);
        obs_q.delete();
        d0 = done_cnt;
        @(posedge clk); #1;
        d = 8'd36; T = 9'd36; q = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; d = 8'd0; q = 1'b0;
        k = 0;
        while (!(fb_valid === 1'b1 && fb_idx === IW'(3)) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        n_tests++;
        if (k >= 200) begin
            n_fail++;
            $display("FAIL stall reach idx3: got no fb_valid with idx 3 within %0d cycles", k);
        end
        fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            held = '{idx: fb_idx, en: fb_en, typ: fb_type};
            n_tests++;
            if (fb_valid !== 1'b1 || held !== exp_at(3) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall hold[%0d]: got valid=%b busy=%b %h, expected valid=1 busy=1 %h",
                         i, fb_valid, busy, held, exp_at(3));
            end
            @(posedge clk); #1;
            start = (i == 1);
        end
        fb_ready = 1'b1;
        start = 1'b0;
        wait_done(500, cyc, to);
        n_tests++;
        if (to || seq_diff() != -1 || done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL stall sample: got timeout=%b diff_at=%0d done=%0d, expected timeout=0 diff_at=-1 done=1",
                     to, seq_diff(), done_cnt - d0);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || fb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall restart: got busy=%b valid=%b after done, expected 0 0", busy, fb_valid);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, d0, k;
        bit to;
        d0 = done_cnt;
        @(posedge clk); #1;
        d = 8'd36; T = 9'd36; q = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!(fb_valid === 1'b1 && fb_idx === IW'(7)) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        n_tests++;
        if (k >= 200) begin
            n_fail++;
            $display("FAIL reset_mid reach idx7: got no fb_valid with idx 7 within %0d cycles", k);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({busy, fb_valid, fb_en, fb_type, done, fb_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got busy=%b valid=%b en=%b type=%b done=%b idx=%0d, expected all 0",
                     busy, fb_valid, fb_en, fb_type, done, fb_idx);
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid abort: got done pulses=%0d busy=%b, expected 0 0", done_cnt - d0, busy);
        end
        m_lfsr = SEED;
        prep_model(36, 36, 1'b0);
        d0 = done_cnt;
        run_sample(8'd36, 9'd36, 1'b0, 500, cyc, to);
        check_sample("after_reset_full", cyc, to, d0);
        // A randomness-consuming sample shows the generator restarted from its seed.
        prep_model(18, 36, 1'b1);
        d0 = done_cnt;
        run_sample(8'd18, 9'd36, 1'b1, 4000, cyc, to);
        check_sample("after_reset_half", cyc, to, d0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_d();
        test_full_d();
        test_random();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
